digit_counter: RTL and testbench

DIGIT_COUNTER -- requirements
Module: digit_counter

---
 rtl/digit_counter_pkg.sv | 23 ++
 rtl/digit_counter_if.sv | 25 ++
 rtl/digit_counter_bcd_to_7seg.sv | 25 ++
 rtl/digit_counter.sv | 99 +++++++++
 tb/tb_digit_counter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/digit_counter_pkg.sv
`timescale 1ns/1ps
// Shared constants for the BCD display counter: digit count default and 7-segment patterns.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package digit_counter_pkg;

    localparam int DIGITS_DEFAULT = 8;

    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/digit_counter_if.sv
`timescale 1ns/1ps
// Strobe/trigger inputs and display drive outputs of the digit counter.
// master = stimulus side, slave = counter side.
interface digit_counter_if
    import digit_counter_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
);
    logic [DIGITS-1:0] trigger;
    logic              inc_clk;
    logic              ref_clk;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_sel;
    logic              overflow;

    modport master (
        output trigger, inc_clk, ref_clk,
        input  seg, dig_sel, overflow
    );

    modport slave (
        input  trigger, inc_clk, ref_clk,
        output seg, dig_sel, overflow
    );
endinterface

// File: rtl/digit_counter_bcd_to_7seg.sv
`timescale 1ns/1ps
// Combinational BCD to 7-segment decode; latency 0, no flow control.
// Non-decimal nibbles blank the digit.
module bcd_to_7seg
    import digit_counter_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/digit_counter.sv
`timescale 1ns/1ps
// Multi-digit BCD counter with strobed display latch and multiplexed 7-segment scan.
// Count updates on the inc_clk edge, display 1 cycle after ref_clk; no backpressure, strobes are level per cycle.
module digit_counter
    import digit_counter_pkg::*;
#(
    parameter int                    DIGITS     = DIGITS_DEFAULT,
    parameter int                    SCAN_WIDTH = 16,
    parameter logic [SCAN_WIDTH-1:0] SCAN_MAX   = 16'd4999
)(
    input  logic            clk,
    input  logic            reset,
    digit_counter_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = 4 * DIGITS;

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [CNT_W-1:0]      display;
    logic                  wrap;
    logic                  overflow_q;
    logic [SCAN_WIDTH-1:0] scan_cnt;
    logic [IDX_W-1:0]      scan_idx;
    bcd_t                  scan_nibble;
    logic [6:0]            seg_dec;

    // Increment enters at the lowest set trigger bit and ripples upward through 9s.
    always_comb begin : inc_logic
        logic carry;
        logic found;
        bcd_t nib;
        count_nxt = count;
        wrap      = 1'b0;
        carry     = 1'b0;
        found     = 1'b0;
        nib       = '0;
        if (bus.inc_clk && (|bus.trigger)) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = count[i*4 +: 4];
                if (!found && bus.trigger[i]) begin
                    found = 1'b1;
                    carry = 1'b1;
                end
                if (carry) begin
                    if (nib >= BCD_MAX) begin
                        nib = '0;
                    end else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                    end
                end
                count_nxt[i*4 +: 4] = nib;
            end
            wrap = carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            display    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count <= count_nxt;
            // Latches the current register, so a coincident increment is not yet visible.
            if (bus.ref_clk) display <= count;
            if (wrap) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.dig_sel           = '0;
        bus.dig_sel[scan_idx] = 1'b1;
    end

    assign scan_nibble = display[{scan_idx, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd (scan_nibble),
        .seg (seg_dec)
    );

    assign bus.seg      = seg_dec;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_digit_counter.sv
`timescale 1ns/1ps
// Directed self-checking bench for digit_counter with DIGITS=8, SCAN_MAX=3.
module tb_digit_counter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [6:0] seg_tab [10];

    always #5 clk = ~clk;

    digit_counter_if #(.DIGITS(8)) bus ();

    digit_counter #(
        .DIGITS     (8),
        .SCAN_WIDTH (16),
        .SCAN_MAX   (16'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic inc_n(input logic [7:0] trig, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.trigger = trig;
            bus.inc_clk = 1'b1;
            @(negedge clk);
            bus.inc_clk = 1'b0;
        end
    endtask

    task automatic ref_pulse();
        @(negedge clk);
        bus.ref_clk = 1'b1;
        @(negedge clk);
        bus.ref_clk = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        bus.trigger = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        bus.trigger = 8'hFF;
        bus.inc_clk = 1'b1;
        bus.ref_clk = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dut.count !== 32'h0) begin bad++; $display("FAIL rst_count got=%h exp=%h", dut.count, 32'h0); end
        total++; if (dut.display !== 32'h0) begin bad++; $display("FAIL rst_display got=%h exp=%h", dut.display, 32'h0); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.dig_sel !== 8'h01) begin bad++; $display("FAIL rst_dig_sel got=%h exp=01", bus.dig_sel); end
        total++; if (bus.seg !== 7'h3F) begin bad++; $display("FAIL rst_seg got=%h exp=3f", bus.seg); end
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        bus.trigger = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_count();
        inc_n(8'h01, 12);
        total++; if (dut.count !== 32'h00000012) begin bad++; $display("FAIL basic_count got=%h exp=%h", dut.count, 32'h12); end
        @(negedge clk);
        bus.ref_clk = 1'b1;
        total++; if (dut.display !== 32'h0) begin bad++; $display("FAIL basic_disp_early got=%h exp=%h", dut.display, 32'h0); end
        @(negedge clk);
        bus.ref_clk = 1'b0;
        total++; if (dut.display !== 32'h00000012) begin bad++; $display("FAIL basic_display got=%h exp=%h", dut.display, 32'h12); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_carry();
        do_reset();
        inc_n(8'h04, 9);
        inc_n(8'h02, 9);
        inc_n(8'h01, 9);
        total++; if (dut.count !== 32'h00000999) begin bad++; $display("FAIL carry_pre got=%h exp=%h", dut.count, 32'h999); end
        inc_n(8'h02, 1);
        total++; if (dut.count !== 32'h00001009) begin bad++; $display("FAIL carry_ripple got=%h exp=%h", dut.count, 32'h1009); end
        inc_n(8'h06, 1);
        total++; if (dut.count !== 32'h00001019) begin bad++; $display("FAIL carry_lowest_bit got=%h exp=%h", dut.count, 32'h1019); end
        inc_n(8'h00, 3);
        total++; if (dut.count !== 32'h00001019) begin bad++; $display("FAIL no_trigger got=%h exp=%h", dut.count, 32'h1019); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL no_trigger_ovf got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        inc_n(8'h01, 5);
        @(negedge clk);
        bus.trigger = 8'h01;
        bus.inc_clk = 1'b1;
        bus.ref_clk = 1'b1;
        @(negedge clk);
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        total++; if (dut.display !== 32'h00000005) begin bad++; $display("FAIL same_display got=%h exp=%h", dut.display, 32'h5); end
        total++; if (dut.count !== 32'h00000006) begin bad++; $display("FAIL same_count got=%h exp=%h", dut.count, 32'h6); end
        // Held strobe: four consecutive edges count as four increments.
        @(negedge clk);
        bus.inc_clk = 1'b1;
        repeat (4) @(negedge clk);
        bus.inc_clk = 1'b0;
        total++; if (dut.count !== 32'h00000010) begin bad++; $display("FAIL held_strobe got=%h exp=%h", dut.count, 32'h10); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int d = 0; d < 8; d++) inc_n(8'(1 << d), 9);
        total++; if (dut.count !== 32'h99999999) begin bad++; $display("FAIL ovf_pre got=%h exp=%h", dut.count, 32'h99999999); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre_flag got=%b exp=0", bus.overflow); end
        inc_n(8'h01, 1);
        total++; if (dut.count !== 32'h0) begin bad++; $display("FAIL ovf_wrap got=%h exp=%h", dut.count, 32'h0); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        inc_n(8'h01, 3);
        total++; if (dut.count !== 32'h00000003) begin bad++; $display("FAIL ovf_after got=%h exp=%h", dut.count, 32'h3); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_scan();
        logic [7:0] prev;
        logic       found;
        int         start;
        int         idx;
        // Count is 3 here: seven more at digit 0 gives 0x10, then digit d gets d increments.
        inc_n(8'h01, 7);
        for (int d = 2; d < 8; d++) inc_n(8'(1 << d), d);
        total++; if (dut.count !== 32'h76543210) begin bad++; $display("FAIL scan_count got=%h exp=%h", dut.count, 32'h76543210); end
        ref_pulse();
        total++; if (dut.display !== 32'h76543210) begin bad++; $display("FAIL scan_display got=%h exp=%h", dut.display, 32'h76543210); end
        prev  = bus.dig_sel;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.dig_sel !== prev) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL scan_advance got=%h exp=change within 10 cycles", bus.dig_sel);
        end else begin
            start = 0;
            for (int j = 0; j < 8; j++) if (bus.dig_sel[j]) start = j;
            for (int step = 0; step < 36; step++) begin
                idx = (start + step / 4) % 8;
                total++; if (bus.dig_sel !== 8'(1 << idx)) begin bad++; $display("FAIL scan_dig_sel step=%0d got=%h exp=%h", step, bus.dig_sel, 8'(1 << idx)); end
                total++; if (bus.seg !== seg_tab[idx]) begin bad++; $display("FAIL scan_seg step=%0d got=%h exp=%h", step, bus.seg, seg_tab[idx]); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_async_reset();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.dig_sel !== 8'h01) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL arst_midscan got=%h exp=not 01", bus.dig_sel); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL arst_pre_ovf got=%b exp=1", bus.overflow); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total++; if (dut.count !== 32'h0) begin bad++; $display("FAIL arst_count got=%h exp=%h", dut.count, 32'h0); end
        total++; if (dut.display !== 32'h0) begin bad++; $display("FAIL arst_display got=%h exp=%h", dut.display, 32'h0); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL arst_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.dig_sel !== 8'h01) begin bad++; $display("FAIL arst_dig_sel got=%h exp=01", bus.dig_sel); end
        total++; if (bus.seg !== 7'h3F) begin bad++; $display("FAIL arst_seg got=%h exp=3f", bus.seg); end
        // A strobe present at the first edge after release must count.
        bus.trigger = 8'h01;
        bus.inc_clk = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (dut.count !== 32'h00000001) begin bad++; $display("FAIL release_inc got=%h exp=%h", dut.count, 32'h1); end
        bus.inc_clk = 1'b0;
    endtask

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        bus.trigger = '0;
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        test_reset();
        test_basic_count();
        test_carry();
        test_same_cycle();
        test_overflow();
        test_scan();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
